pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 pc_stall  input  1  hazard request: 1 = hold PC.
REQ-004 ifid_hold  input  1  hazard request: 1 = hold IF/ID register.
REQ-005 bubble_sel  input  1  hazard request: 1 = inject bubble into ID/EX.
REQ-006 branch_taken_EX  input  1  taken branch/jump resolved in EX.
REQ-007 branch_target_EX  input  32  redirect address.
REQ-008 instr_IF  input  32  fetched instruction at pc_IF.
REQ-009 ctrl_ID  input  16  decoded control bundle of instruction in ID.
REQ-010 pc_IF  output  32  fetch PC.
REQ-011 pc_IF_ID, instr_IF_ID  output  32 each  IF/ID register contents.
REQ-012 valid_IF_ID  output  1  IF/ID holds a real instruction.
REQ-013 ctrl_ID_EX  output  16  ID/EX control register.
REQ-014 valid_ID_EX  output  1  ID/EX holds a real instruction.
REQ-015 state  output  2  FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-016 stall_cnt, flush_cnt  output  16 each  saturating event counters.
REQ-017 hz_err  output  1  sticky: hazard inputs disagreed.

Function
REQ-018 Effective stall stall_eff SHALL be pc_stall OR ifid_hold OR bubble_sel, forced to 0 when state==FLUSH or branch_taken_EX=1.
REQ-019 PC SHALL update each cycle: branch_taken_EX -> branch_target_EX; else stall_eff -> hold; else pc_IF+4, modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
REQ-020 IF/ID SHALL update: branch_taken_EX -> instr 0x00000013, pc unchanged, valid 0; else stall_eff -> hold all fields; else capture instr_IF, pc_IF, valid 1.
REQ-021 ID/EX SHALL update: branch_taken_EX or stall_eff -> ctrl 0, valid 0; else ctrl_ID_EX<=ctrl_ID, valid_ID_EX<=valid_IF_ID.
REQ-022 ctrl_ID_EX SHALL be 0 whenever valid_ID_EX=0 (invariant).
REQ-023 FSM: any state with branch_taken_EX=1 -> FLUSH; else stall_eff=1 -> STALL; else -> RUN.
REQ-024 FLUSH SHALL last exactly one cycle absent another branch; back-to-back branches keep FSM in FLUSH and each increments flush_cnt.
REQ-025 Hazard inputs SHALL be ignored in FLUSH (IF/ID is a bubble); no stall, no stall_cnt increment.
REQ-026 stall_cnt SHALL increment once per cycle with stall_eff=1; flush_cnt once per cycle with branch_taken_EX=1; both saturate at 0xFFFF.
REQ-027 hz_err SHALL set when {pc_stall, ifid_hold, bubble_sel} not all equal in a non-FLUSH cycle, and clear only on reset.
REQ-028 Latency: redirect visible on pc_IF one cycle after branch_taken_EX; stall holds visible in the same cycle it is sampled.

Reset
REQ-029 rst=0 SHALL immediately force: pc_IF=0, pc_IF_ID=0, instr_IF_ID=0x00000013, valid_IF_ID=0, ctrl_ID_EX=0, valid_ID_EX=0, state=RUN, counters=0, hz_err=0.
REQ-030 Reset mid-stall or mid-flush SHALL abandon the operation with no residual hold; first fetch after release is at 0x00000000.

Structure
REQ-031 Shared package pipe_pkg SHALL hold: NOP encoding 32'h00000013, PC reset value, state encodings, ctrl bundle width 16, counter width 16.
REQ-032 One sub-module sat_counter (16-bit, enable, saturating, async active-low reset) SHALL be instantiated twice.
REQ-033 No combinational path from ctrl_ID or instr_IF to any output.

Verification
REQ-034 Reset release, no hazards, 4 cycles -> pc_IF 0,4,8,12; valid_IF_ID=1 from cycle 2; state=RUN.
REQ-035 All three hazard inputs =1 for 1 cycle at pc_IF=0x10 -> pc_IF stays 0x10, IF/ID held, ctrl_ID_EX=0, valid_ID_EX=0, state=STALL, stall_cnt=1, hz_err=0.
REQ-036 branch_taken_EX=1, target 0x200, together with all hazard inputs =1 -> pc_IF=0x200, instr_IF_ID=0x00000013, valid_IF_ID=0, state=FLUSH, flush_cnt=1, stall_cnt unchanged.
REQ-037 Only pc_stall=1 for 1 cycle -> treated as stall, hz_err=1 and stays 1 after 10 clean cycles.
REQ-038 Force pc_IF to 0xFFFFFFFC, no hazard -> next pc_IF=0x00000000; 70000 stall cycles -> stall_cnt=0xFFFF.
REQ-039 Assert rst=0 mid-STALL between clock edges -> all outputs take reset values before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and widths for the pipeline controller
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_RESET  = 32'h0000_0000;
   localparam int          CTRL_W    = 16;
   localparam int          CNT_W     = 16;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Sequential fetch wraps naturally at 2^32.
   function automatic logic [31:0] pc_seq(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - fetch PC, IF/ID and ID/EX registers with stall/flush control
module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_stall,
   input  logic              ifid_hold,
   input  logic              bubble_sel,
   input  logic              branch_taken_EX,
   input  logic [31:0]       branch_target_EX,
   input  logic [31:0]       instr_IF,
   input  logic [CTRL_W-1:0] ctrl_ID,
   output logic [31:0]       pc_IF,
   output logic [31:0]       pc_IF_ID,
   output logic [31:0]       instr_IF_ID,
   output logic              valid_IF_ID,
   output logic [CTRL_W-1:0] ctrl_ID_EX,
   output logic              valid_ID_EX,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              hz_err
);

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       ifid_pc_q, ifid_pc_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
   logic              idex_valid_q, idex_valid_d;
   logic              hz_err_q, hz_err_d;

   logic in_flush;
   logic stall_eff;
   logic hz_mismatch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = ST_RUN;
      if (branch_taken_EX) begin
         state_d = ST_FLUSH;
      end else if (stall_eff) begin
         state_d = ST_STALL;
      end
   end

   // The cycle after a redirect holds a bubble in IF/ID, so hazard requests are meaningless then.
   always_comb begin
      in_flush    = (state_q == ST_FLUSH);
      stall_eff   = (pc_stall | ifid_hold | bubble_sel) & ~in_flush & ~branch_taken_EX;
      hz_mismatch = ~in_flush & ~((pc_stall == ifid_hold) && (ifid_hold == bubble_sel));
   end

   always_comb begin
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      idex_ctrl_d  = idex_ctrl_q;
      idex_valid_d = idex_valid_q;
      hz_err_d     = hz_err_q | hz_mismatch;

      if (branch_taken_EX) begin
         pc_d         = branch_target_EX;
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
      end else if (!stall_eff) begin
         pc_d         = pc_seq(pc_q);
         ifid_pc_d    = pc_q;
         ifid_instr_d = instr_IF;
         ifid_valid_d = 1'b1;
      end

      // A killed ID/EX slot always carries zero control so downstream never acts on it.
      if (branch_taken_EX || stall_eff) begin
         idex_ctrl_d  = '0;
         idex_valid_d = 1'b0;
      end else begin
         idex_ctrl_d  = ifid_valid_q ? ctrl_ID : '0;
         idex_valid_d = ifid_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= PC_RESET;
         ifid_pc_q    <= PC_RESET;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         idex_ctrl_q  <= '0;
         idex_valid_q <= 1'b0;
         hz_err_q     <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         idex_ctrl_q  <= idex_ctrl_d;
         idex_valid_q <= idex_valid_d;
         hz_err_q     <= hz_err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst),
      .en    (stall_eff),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst),
      .en    (branch_taken_EX),
      .cnt   (flush_cnt)
   );

   assign state       = state_q;
   assign pc_IF       = pc_q;
   assign pc_IF_ID    = ifid_pc_q;
   assign instr_IF_ID = ifid_instr_q;
   assign valid_IF_ID = ifid_valid_q;
   assign ctrl_ID_EX  = idex_ctrl_q;
   assign valid_ID_EX = idex_valid_q;
   assign hz_err      = hz_err_q;

endmodule
